// File: rtl/score_digits_pkg.sv
// Shared types and constants for the score-to-decimal-digit encoder.
package score_digits_pkg;

  localparam int unsigned SCORE_W      = 14;
  localparam int unsigned BCD_W        = 16;
  localparam int unsigned SCORE_MAXVAL = 9999;

  typedef logic [3:0] digit_t;

  localparam digit_t DIGIT_BLANK = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

endpackage

// File: rtl/score_digits_add3_nibble.sv
// Double-dabble correction step: a BCD nibble of 5 or more gets +3 before the shift.
module score_digits_add3_nibble
  import score_digits_pkg::*;
(
  input  digit_t nib_i,
  output digit_t nib_o
);

  assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;

endmodule

// File: rtl/score_digits.sv
// Sequential binary-to-BCD digit encoder with leading-zero blanking; digits
// only change on the FINISH edge so the display never sees partial results.
module score_digits
  import score_digits_pkg::*;
#(
  parameter int unsigned W      = SCORE_W,
  parameter digit_t      BLANK  = DIGIT_BLANK,
  parameter int unsigned MAXVAL = SCORE_MAXVAL
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic [W-1:0] value,
  input  logic         blank_en,
  output logic         busy,
  output logic         done,
  output digit_t       digitL,
  output digit_t       digitML,
  output digit_t       digitMR,
  output digit_t       digitR
);

  localparam int unsigned SR_W  = BCD_W + W;
  localparam int unsigned CNT_W = $clog2(W + 1);

  state_e             state_q, state_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic               blank_q, blank_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  digit_t             dl_q, dl_d, dml_q, dml_d, dmr_q, dmr_d, dr_q, dr_d;

  logic [W-1:0]       sat_value;
  logic [BCD_W-1:0]   bcd_adj;
  digit_t             n3, n2, n1, n0;
  logic               z3, z32, z321;

  assign sat_value = (value > W'(MAXVAL)) ? W'(MAXVAL) : value;

  // Per-nibble +3 correction on the BCD half of the shift register.
  for (genvar g = 0; g < 4; g++) begin : g_add3
    score_digits_add3_nibble u_add3 (
      .nib_i (sr_q[W + 4*g +: 4]),
      .nib_o (bcd_adj[4*g +: 4])
    );
  end

  assign n3   = sr_q[W + 12 +: 4];
  assign n2   = sr_q[W + 8  +: 4];
  assign n1   = sr_q[W + 4  +: 4];
  assign n0   = sr_q[W      +: 4];
  // Leading-zero run from the left; interior zeros stay visible.
  assign z3   = (n3 == 4'd0);
  assign z32  = z3  && (n2 == 4'd0);
  assign z321 = z32 && (n1 == 4'd0);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= ST_IDLE;
      sr_q     <= '0;
      bitcnt_q <= '0;
      blank_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dl_q     <= BLANK;
      dml_q    <= BLANK;
      dmr_q    <= BLANK;
      dr_q     <= 4'd0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      bitcnt_q <= bitcnt_d;
      blank_q  <= blank_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dl_q     <= dl_d;
      dml_q    <= dml_d;
      dmr_q    <= dmr_d;
      dr_q     <= dr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    bitcnt_d = bitcnt_q;
    blank_d  = blank_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dl_d     = dl_q;
    dml_d    = dml_q;
    dmr_d    = dmr_q;
    dr_d     = dr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sr_d     = {BCD_W'(0), sat_value};
          bitcnt_d = CNT_W'(W);
          blank_d  = blank_en;
          busy_d   = 1'b1;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sr_d     = {bcd_adj, sr_q[W-1:0]} << 1;
        bitcnt_d = bitcnt_q - CNT_W'(1);
        if (bitcnt_q == CNT_W'(1)) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        dl_d    = (blank_q && z3)   ? BLANK : n3;
        dml_d   = (blank_q && z32)  ? BLANK : n2;
        dmr_d   = (blank_q && z321) ? BLANK : n1;
        dr_d    = n0;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign digitL  = dl_q;
  assign digitML = dml_q;
  assign digitMR = dmr_q;
  assign digitR  = dr_q;

endmodule

// File: tb/tb_score_digits.sv
// Bench for score_digits: directed cases plus random conversions checked
// against an arithmetic decimal-digit model.
module tb_score_digits;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [13:0] value;
  logic        blank_en;
  logic        busy, done;
  logic [3:0]  digitL, digitML, digitMR, digitR;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_prev;

  score_digits dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .value    (value),
    .blank_en (blank_en),
    .busy     (busy),
    .done     (done),
    .digitL   (digitL),
    .digitML  (digitML),
    .digitMR  (digitMR),
    .digitR   (digitR)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Decimal digits of the saturated score; leading zeros blanked by magnitude.
  function automatic logic [15:0] model(input int unsigned v, input bit b);
    int unsigned s;
    int unsigned d3, d2, d1, d0;
    s  = (v > 9999) ? 9999 : v;
    d3 = s / 1000;
    d2 = (s / 100) % 10;
    d1 = (s / 10) % 10;
    d0 = s % 10;
    if (b) begin
      if (s < 1000) d3 = 10;
      if (s < 100)  d2 = 10;
      if (s < 10)   d1 = 10;
    end
    return {4'(d3), 4'(d2), 4'(d1), 4'(d0)};
  endfunction

  function automatic logic [15:0] digits();
    return {digitL, digitML, digitMR, digitR};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One conversion; start re-pulsed at edges r1/r2 (with scrambled inputs) must be ignored.
  task automatic conv(input logic [13:0] v, input bit b, input int r1, input int r2);
    logic [15:0] expd;
    expd = model(v, b);
    @(negedge clk);
    value = v; blank_en = b; start = 1'b1;
    for (int e = 0; e <= 15; e++) begin
      @(posedge clk);
      @(negedge clk);
      start    = ((e + 1) == r1) || ((e + 1) == r2);
      value    = 14'($urandom);
      blank_en = ~b;
      if (e < 15) begin
        check("busy_in_flight", 16'(busy), 16'd1);
        check("no_early_done", 16'(done), 16'd0);
        check("digits_held", digits(), exp_prev);
      end else begin
        check("done_pulse", 16'(done), 16'd1);
        check("busy_clear", 16'(busy), 16'd0);
        check("digits_result", digits(), expd);
      end
    end
    start = 1'b0;
    exp_prev = expd;
    @(posedge clk);
    @(negedge clk);
    check("done_one_cycle", 16'(done), 16'd0);
    check("digits_stable", digits(), exp_prev);
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; value = '0; blank_en = 1'b0;
    exp_prev = {4'd10, 4'd10, 4'd10, 4'd0};
    #12;
    check("reset_digits", digits(), exp_prev);
    check("reset_busy", 16'(busy), 16'd0);
    check("reset_done", 16'(done), 16'd0);
    @(negedge clk);
    clr = 1'b0;

    conv(14'd0,     1'b1, -1, -1);
    conv(14'd42,    1'b1, -1, -1);
    conv(14'd1005,  1'b1, -1, -1);
    conv(14'd12000, 1'b1, -1, -1);
    conv(14'd16383, 1'b0, -1, -1);
    conv(14'd7,     1'b0, -1, -1);
    conv(14'd123,   1'b1,  3, 14);
    conv(14'd9999,  1'b1, -1, -1);
    conv(14'd1000,  1'b1, -1, -1);

    // Start held high: second conversion accepted on the first IDLE edge.
    @(negedge clk);
    value = 14'd300; blank_en = 1'b1; start = 1'b1;
    @(posedge clk); @(negedge clk);
    value = 14'd8; blank_en = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      @(posedge clk); @(negedge clk);
    end
    check("b2b_first_done", 16'(done), 16'd1);
    check("b2b_first_digits", digits(), model(300, 1'b1));
    @(posedge clk); @(negedge clk);
    start = 1'b0; value = 14'd1; blank_en = 1'b1;
    check("b2b_second_busy", 16'(busy), 16'd1);
    check("b2b_done_low", 16'(done), 16'd0);
    for (int e = 17; e <= 31; e++) begin
      @(posedge clk); @(negedge clk);
    end
    check("b2b_second_done", 16'(done), 16'd1);
    check("b2b_second_digits", digits(), model(8, 1'b0));
    exp_prev = model(8, 1'b0);
    @(posedge clk); @(negedge clk);

    // Asynchronous clear in the middle of a conversion.
    value = 14'd9876; blank_en = 1'b1; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    for (int e = 1; e <= 8; e++) @(posedge clk);
    #2 clr = 1'b1;
    #1;
    check("clr_digits_async", digits(), {4'd10, 4'd10, 4'd10, 4'd0});
    check("clr_busy_async", 16'(busy), 16'd0);
    check("clr_done_async", 16'(done), 16'd0);
    @(negedge clk);
    clr = 1'b0;
    exp_prev = {4'd10, 4'd10, 4'd10, 4'd0};
    for (int e = 0; e < 10; e++) begin
      @(posedge clk); @(negedge clk);
      check("clr_no_done", 16'(done), 16'd0);
      check("clr_idle_busy", 16'(busy), 16'd0);
    end
    conv(14'd55, 1'b1, -1, -1);

    // Random conversions, with occasional ignored re-pulses of start.
    for (int i = 0; i < 16; i++) begin
      logic [13:0] rv;
      int r1;
      case ($urandom_range(0, 3))
        0:       rv = 14'($urandom_range(0, 9));
        1:       rv = 14'($urandom_range(10, 999));
        2:       rv = 14'($urandom_range(1000, 9999));
        default: rv = 14'($urandom);
      endcase
      r1 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 14)) : -1;
      conv(rv, 1'($urandom_range(0, 1)), r1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
